// File: rtl/image_memory_simd_port_if.sv
// image_memory_simd_port_if: read-lane and write-port bundle for the SIMD frame buffer
//   rd_req/rd_addr   per-lane read request and byte address (master -> slave)
//   rd_valid/rd_data per-lane level response, held until the next accepted request (slave -> master)
//   we/wr_addr/wr_data single write-through byte port (master -> slave)
interface image_memory_simd_port_if #(
    parameter int N  = 4,
    parameter int AW = 8
);
    logic [N-1:0]         rd_req;
    logic [N-1:0][AW-1:0] rd_addr;
    logic [N-1:0]         rd_valid;
    logic [N-1:0][7:0]    rd_data;
    logic                 we;
    logic [AW-1:0]        wr_addr;
    logic [7:0]           wr_data;

    modport master (
        output rd_req, rd_addr, we, wr_addr, wr_data,
        input  rd_valid, rd_data
    );

    modport slave (
        input  rd_req, rd_addr, we, wr_addr, wr_data,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/image_memory_simd_port.sv
// image_memory_simd_port: byte frame buffer with N single-line cached read lanes and a shared fill engine
//   clk  rising-edge clock
//   rst  synchronous active-high reset (lanes idle, lines invalid, responses zero, fill aborted)
//   bus  slave side of image_memory_simd_port_if (lane requests/responses and the write port)
module image_memory_simd_port #(
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int N         = 4,
    parameter int LINE_SIZE = 8,
    localparam int DEPTH    = IMG_W * IMG_H,
    localparam int AW       = $clog2(DEPTH)
) (
    input logic                     clk,
    input logic                     rst,
    image_memory_simd_port_if.slave bus
);
    localparam int OW  = $clog2(LINE_SIZE);
    localparam int OFW = OW > 0 ? OW : 1;
    localparam int TW  = AW - OW;
    localparam int LW  = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_FILL} state_e;

    function automatic logic [TW-1:0] tag_of(input logic [AW-1:0] a);
        return TW'(a >> OW);
    endfunction

    function automatic logic [OFW-1:0] off_of(input logic [AW-1:0] a);
        return OFW'(a & AW'(LINE_SIZE - 1));
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW + 1)'(DEPTH);
    endfunction

    logic [7:0]        mem_q [DEPTH];
    state_e            st_q [N];
    state_e            st_d [N];
    logic [AW-1:0]     addr_q [N];
    logic [TW-1:0]     tag_q [N];
    logic [N-1:0]      vld_q;
    logic [7:0]        line_q [N][LINE_SIZE];
    logic [N-1:0]      rv_q;
    logic [N-1:0][7:0] rdat_q;
    logic              busy_q;
    logic              cmp_q;
    logic [LW-1:0]     fl_q;
    logic [LW-1:0]     cl_q;
    logic [LW-1:0]     ptr_q;
    logic [OFW-1:0]    cnt_q;
    logic [N-1:0]      hit;
    logic [N-1:0]      miss;
    logic [N-1:0]      done;
    logic [N-1:0]      fill_req;
    logic              gnt_any;
    logic [LW-1:0]     gnt;
    logic              wr_ok;
    logic              fetch_en;
    logic              last;
    logic [LW-1:0]     flane;
    logic [OFW-1:0]    fidx;
    logic [AW-1:0]     faddr;
    logic [7:0]        fbyte;

    // Lane outputs. A lane already owning the fill engine (fetching or
    // awaiting its completion edge) stops requesting.
    always_comb begin
        hit      = '0;
        miss     = '0;
        done     = '0;
        fill_req = '0;
        for (int i = 0; i < N; i++) begin
            hit[i]      = st_q[i] == LOOKUP && vld_q[i] && tag_q[i] == tag_of(addr_q[i]);
            miss[i]     = st_q[i] == LOOKUP && !hit[i];
            done[i]     = st_q[i] == WAIT_FILL && cmp_q && cl_q == LW'(i);
            fill_req[i] = miss[i] || (st_q[i] == WAIT_FILL
                          && !(busy_q && fl_q == LW'(i)) && !(cmp_q && cl_q == LW'(i)));
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            st_d[i] = st_q[i] == IDLE   ? (bus.rd_req[i] ? LOOKUP : IDLE)
                    : st_q[i] == LOOKUP ? (hit[i] ? IDLE : WAIT_FILL)
                    : done[i]           ? IDLE : st_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            st_q[i] <= rst ? IDLE : st_d[i];
        end
    end

    // Round-robin pick: scanning downward lets the lane nearest the pointer win.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (fill_req[(int'(ptr_q) + k) % N]) begin
                gnt_any = 1'b1;
                gnt     = LW'((int'(ptr_q) + k) % N);
            end
        end
    end

    // A grant fetches byte 0 on its own edge; the completion edge after the
    // last byte doubles as the next grant, so fills run back-to-back.
    assign wr_ok    = bus.we && in_range(bus.wr_addr);
    assign fetch_en = busy_q || gnt_any;
    assign flane    = busy_q ? fl_q : gnt;
    assign fidx     = busy_q ? cnt_q : '0;
    assign last     = fidx == OFW'(LINE_SIZE - 1);
    assign faddr    = (addr_q[flane] & ~AW'(LINE_SIZE - 1)) | AW'(fidx);
    assign fbyte    = !in_range(faddr) ? 8'h00
                    : (wr_ok && bus.wr_addr == faddr) ? bus.wr_data : mem_q[faddr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            rv_q   <= '0;
            rdat_q <= '0;
            busy_q <= 1'b0;
            cmp_q  <= 1'b0;
            ptr_q  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (st_q[i] == IDLE && bus.rd_req[i]) begin
                    addr_q[i] <= bus.rd_addr[i];
                    rv_q[i]   <= 1'b0;
                end
                if (hit[i] || done[i]) begin
                    rv_q[i]   <= 1'b1;
                    rdat_q[i] <= line_q[i][off_of(addr_q[i])];
                end
                if (miss[i]) begin
                    tag_q[i] <= tag_of(addr_q[i]);
                    vld_q[i] <= 1'b0;
                end
                if (done[i]) vld_q[i] <= 1'b1;
                // Lines mid-fill are kept coherent too, so bytes fetched before a write stay current.
                if (wr_ok && (vld_q[i] || st_q[i] == WAIT_FILL) && tag_q[i] == tag_of(bus.wr_addr))
                    line_q[i][off_of(bus.wr_addr)] <= bus.wr_data;
            end
            if (fetch_en) line_q[flane][fidx] <= fbyte;
            busy_q <= fetch_en && !last;
            cmp_q  <= fetch_en && last;
            fl_q   <= flane;
            cl_q   <= flane;
            cnt_q  <= fidx + 1'b1;
            if (gnt_any && !busy_q) ptr_q <= gnt == LW'(N - 1) ? '0 : gnt + 1'b1;
        end
    end

    assign bus.rd_valid = rv_q;
    assign bus.rd_data  = rdat_q;
endmodule

// File: tb/tb_image_memory_simd_port.sv
// tb_image_memory_simd_port: directed bench with a transaction-level lane/arbiter model checked every cycle
module tb_image_memory_simd_port;
    localparam int N     = 4;
    localparam int LS    = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    image_memory_simd_port_if #(.N(N), .AW(AW)) bus ();

    image_memory_simd_port #(.IMG_W(16), .IMG_H(16), .N(N), .LINE_SIZE(LS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Model: memory contents, per-lane cached line identity, and a fill
    // engine that is busy for LS edges per grant, picked round-robin.
    logic [7:0] ref_mem [DEPTH];
    int  mode [N];
    int  due [N];
    int  maddr [N];
    int  mtag [N];
    bit  mvld [N];
    bit  pend [N];
    bit  ev [N];
    int  ed [N];
    int  eng_free = 0;
    int  rr = 0;

    always @(posedge clk) begin
        bit acc [N];
        cyc++;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mode[i] = 0; mvld[i] = 0; pend[i] = 0; ev[i] = 0; ed[i] = 0; due[i] = -1;
            end
            eng_free = 0;
            rr = 0;
        end else begin
            for (int i = 0; i < N; i++) acc[i] = mode[i] == 0 && bus.rd_req[i];
            for (int i = 0; i < N; i++) begin
                if (mode[i] == 2 && due[i] == cyc) begin
                    ev[i] = 1; ed[i] = ref_mem[maddr[i]]; mvld[i] = 1; mode[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (mode[i] == 1) begin
                    if (mvld[i] && mtag[i] == maddr[i] / LS) begin
                        ev[i] = 1; ed[i] = ref_mem[maddr[i]]; mode[i] = 0;
                    end else begin
                        mvld[i] = 0; mtag[i] = maddr[i] / LS; mode[i] = 2; pend[i] = 1; due[i] = -1;
                    end
                end
            end
            if (cyc >= eng_free) begin
                for (int k = 0; k < N; k++) begin
                    if (pend[(rr + k) % N]) begin
                        int j;
                        j = (rr + k) % N;
                        pend[j] = 0; due[j] = cyc + LS; eng_free = cyc + LS; rr = (j + 1) % N;
                        break;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    mode[i] = 1; maddr[i] = int'(bus.rd_addr[i]); ev[i] = 0;
                end
            end
            if (bus.we) ref_mem[bus.wr_addr] = bus.wr_data;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("valid%0d@%0d", i, cyc), int'(bus.rd_valid[i]), int'(ev[i]));
            chk($sformatf("data%0d@%0d", i, cyc), int'(bus.rd_data[i]), ed[i]);
        end
    end

    task automatic write_b(input int a, input int d);
        bus.we = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = 8'(d);
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic issue(input logic [N-1:0] m, input logic [N-1:0][AW-1:0] a, output int t);
        bus.rd_req = m; bus.rd_addr = a;
        @(negedge clk);
        t = cyc;
        bus.rd_req = '0;
    endtask

    task automatic wait_lane(input int l, input int t, input int exp_lat, input int exp_d, input string nm);
        int lat;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (bus.rd_valid[l]) begin
                lat = cyc - t;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_data"}, int'(bus.rd_data[l]), exp_d);
    endtask

    initial begin
        int t;
        bus.rd_req = '0; bus.rd_addr = '0; bus.we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("rst_valid", int'(bus.rd_valid[i]), 0);
            chk("rst_data", int'(bus.rd_data[i]), 0);
        end
        for (int i = 0; i < 40; i++) write_b(i, i + 10);
        issue(4'hF, {8'd12, 8'd8, 8'd4, 8'd0}, t);
        wait_lane(0, t, 9, 10, "miss0");
        wait_lane(1, t, 17, 14, "miss1");
        wait_lane(2, t, 25, 18, "miss2");
        wait_lane(3, t, 33, 22, "miss3");
        repeat (3) @(negedge clk);
        issue(4'hF, {8'd12, 8'd8, 8'd4, 8'd0}, t);
        wait_lane(0, t, 1, 10, "hit0");
        wait_lane(1, t, 1, 14, "hit1");
        wait_lane(2, t, 1, 18, "hit2");
        wait_lane(3, t, 1, 22, "hit3");
        write_b(4, 8'hAB);
        issue(4'b0010, {8'd0, 8'd0, 8'd4, 8'd0}, t);
        wait_lane(1, t, 1, 8'hAB, "coherent");
        issue(4'b0001, {24'd0, 8'd16}, t);
        @(negedge clk);
        @(negedge clk);
        write_b(17, 8'h77);
        wait_lane(0, t, 9, 26, "midfill_miss");
        issue(4'b0001, {24'd0, 8'd17}, t);
        wait_lane(0, t, 1, 8'h77, "midfill_wr");
        issue(4'b0100, {8'd0, 8'd24, 16'd0}, t);
        @(negedge clk);
        write_b(25, 8'h99);
        wait_lane(2, t, 9, 34, "bypass_miss");
        issue(4'b0100, {8'd0, 8'd25, 16'd0}, t);
        wait_lane(2, t, 1, 8'h99, "bypass_wr");
        issue(4'b1000, {8'd32, 24'd0}, t);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("midrst_valid", int'(bus.rd_valid[i]), 0);
            chk("midrst_data", int'(bus.rd_data[i]), 0);
        end
        issue(4'b0001, {24'd0, 8'd0}, t);
        wait_lane(0, t, 9, 10, "post_rst");
        write_b(255, 8'h5A);
        issue(4'b0010, {16'd0, 8'd255, 8'd0}, t);
        @(negedge clk);
        @(negedge clk);
        bus.rd_req = 4'b0010; bus.rd_addr = {16'd0, 8'd0, 8'd0};
        @(negedge clk);
        bus.rd_req = '0;
        wait_lane(1, t, 9, 8'h5A, "ignored_req");
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
